// File: rtl/dsp_xfer_pkg.sv
// Shared types and constants for the DSP-side transfer sequencer.
// Holds the job state encoding, unit-select codes and the default stall timeout.
package dsp_xfer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StCompute,
    StWrite,
    StDone
  } xfer_state_e;

  localparam logic [1:0] UNIT_FFT     = 2'd0;
  localparam logic [1:0] UNIT_FIR     = 2'd1;
  localparam logic [1:0] UNIT_IIR     = 2'd2;
  localparam logic [1:0] UNIT_ILLEGAL = 2'd3;

  localparam int unsigned TIMEOUT_DEFAULT = 4096;

  // Bit order is {IIR, FIR, FFT}; the illegal code maps to all zero.
  function automatic logic [2:0] unit_onehot(input logic [1:0] sel);
    return 3'b001 << sel;
  endfunction

endpackage

// File: rtl/xfer_watchdog.sv
// Stall counter for the transfer sequencer: counts consecutive stalled cycles
// and flags the cycle on which one more stall reaches the timeout.
module xfer_watchdog #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic step,
  output logic tc
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(TIMEOUT - 1);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt_q <= '0;
    end else if (step) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign tc = (cnt_q == LAST);

endmodule

// File: rtl/dsp_xfer_sequencer.sv
// Job sequencer driving the enable/pause handshake of one DSP unit at a time
// through read, compute and write phases, with a stall watchdog.
module dsp_xfer_sequencer
  import dsp_xfer_pkg::*;
#(
  parameter int unsigned TIMEOUT_W = 16,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  unit_sel,
  input  logic        dsp_in_ready,
  input  logic        dsp_out_valid,
  input  logic        fft_read_done,
  input  logic        fft_write_done,
  input  logic        fir_read_done,
  input  logic        fir_write_done,
  input  logic        iir_read_done,
  input  logic        iir_write_done,
  output logic        fft_enable,
  output logic        fir_enable,
  output logic        iir_enable,
  output logic        fft_read_pause,
  output logic        fft_write_pause,
  output logic        fir_read_pause,
  output logic        fir_write_pause,
  output logic        iir_read_pause,
  output logic        iir_write_pause,
  output logic        busy,
  output logic        job_done,
  output logic        error,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);

  xfer_state_e state_q;
  logic [2:0]  en_q;
  logic [2:0]  rd_pause_q;
  logic [2:0]  wr_pause_q;
  logic        busy_q;
  logic        job_done_q;
  logic        error_q;
  logic [31:0] rd_count_q;
  logic [31:0] wr_count_q;

  logic [2:0] rd_done_vec;
  logic [2:0] wr_done_vec;
  logic       rd_done_sel;
  logic       wr_done_sel;
  logic       rd_inc;
  logic       wr_inc;
  logic       progress;
  logic       stall;
  logic       wd_tc;
  logic       abort;

  assign rd_done_vec = {iir_read_done, fir_read_done, fft_read_done};
  assign wr_done_vec = {iir_write_done, fir_write_done, fft_write_done};

  // en_q doubles as the unit select while a job is active.
  always_comb begin
    rd_done_sel = |(rd_done_vec & en_q);
    wr_done_sel = |(wr_done_vec & en_q);
    rd_inc      = (state_q == StRead) && !rd_done_sel && !(|(rd_pause_q & en_q));
    wr_inc      = (state_q == StWrite) && !wr_done_sel && !(|(wr_pause_q & en_q));
    progress    = 1'b1;
    case (state_q)
      StRead:    progress = rd_done_sel | rd_inc;
      StCompute: progress = dsp_out_valid;
      StWrite:   progress = wr_done_sel | wr_inc;
      default:   progress = 1'b1;
    endcase
    stall = !progress;
    abort = stall && wd_tc;
  end

  xfer_watchdog #(
    .WIDTH   (TIMEOUT_W),
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (!stall),
    .step  (stall),
    .tc    (wd_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      en_q       <= '0;
      rd_pause_q <= '1;
      wr_pause_q <= '1;
      busy_q     <= 1'b0;
      job_done_q <= 1'b0;
      error_q    <= 1'b0;
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      job_done_q <= 1'b0;
      if (abort) begin
        state_q    <= StIdle;
        en_q       <= '0;
        rd_pause_q <= '1;
        wr_pause_q <= '1;
        busy_q     <= 1'b0;
        error_q    <= 1'b1;
      end else begin
        case (state_q)
          StIdle: begin
            if (start) begin
              if (unit_sel == UNIT_ILLEGAL) begin
                error_q <= 1'b1;
              end else begin
                en_q       <= unit_onehot(unit_sel);
                busy_q     <= 1'b1;
                error_q    <= 1'b0;
                rd_count_q <= '0;
                wr_count_q <= '0;
                state_q    <= StRead;
              end
            end
          end
          StRead: begin
            if (rd_done_sel) begin
              rd_pause_q <= '1;
              state_q    <= StCompute;
            end else begin
              rd_pause_q <= (rd_pause_q & ~en_q) | (en_q & {3{~dsp_in_ready}});
            end
            if (rd_inc) rd_count_q <= rd_count_q + 32'd1;
          end
          StCompute: begin
            // The valid that ends compute also releases the first write word.
            if (dsp_out_valid) begin
              wr_pause_q <= wr_pause_q & ~en_q;
              state_q    <= StWrite;
            end
          end
          StWrite: begin
            if (wr_done_sel) begin
              wr_pause_q <= '1;
              job_done_q <= 1'b1;
              state_q    <= StDone;
            end else begin
              wr_pause_q <= (wr_pause_q & ~en_q) | (en_q & {3{~dsp_out_valid}});
            end
            if (wr_inc) wr_count_q <= wr_count_q + 32'd1;
          end
          StDone: begin
            en_q    <= '0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign fft_enable      = en_q[0];
  assign fir_enable      = en_q[1];
  assign iir_enable      = en_q[2];
  assign fft_read_pause  = rd_pause_q[0];
  assign fir_read_pause  = rd_pause_q[1];
  assign iir_read_pause  = rd_pause_q[2];
  assign fft_write_pause = wr_pause_q[0];
  assign fir_write_pause = wr_pause_q[1];
  assign iir_write_pause = wr_pause_q[2];
  assign busy            = busy_q;
  assign job_done        = job_done_q;
  assign error           = error_q;
  assign rd_count        = rd_count_q;
  assign wr_count        = wr_count_q;

endmodule

// File: tb/tb_dsp_xfer_sequencer.sv
// Self-checking bench for dsp_xfer_sequencer: scenario tasks drive jobs and
// queue expected word counts; a monitor pops them on each job_done pulse.
module tb_dsp_xfer_sequencer;
  import dsp_xfer_pkg::*;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  unit_sel;
  logic        dsp_in_ready;
  logic        dsp_out_valid;
  logic        fft_read_done, fft_write_done;
  logic        fir_read_done, fir_write_done;
  logic        iir_read_done, iir_write_done;
  logic        fft_enable, fir_enable, iir_enable;
  logic        fft_read_pause, fft_write_pause;
  logic        fir_read_pause, fir_write_pause;
  logic        iir_read_pause, iir_write_pause;
  logic        busy, job_done, error;
  logic [31:0] rd_count, wr_count;

  always #5 clk = ~clk;

  dsp_xfer_sequencer #(
    .TIMEOUT_W (16),
    .TIMEOUT   (TO)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .unit_sel        (unit_sel),
    .dsp_in_ready    (dsp_in_ready),
    .dsp_out_valid   (dsp_out_valid),
    .fft_read_done   (fft_read_done),
    .fft_write_done  (fft_write_done),
    .fir_read_done   (fir_read_done),
    .fir_write_done  (fir_write_done),
    .iir_read_done   (iir_read_done),
    .iir_write_done  (iir_write_done),
    .fft_enable      (fft_enable),
    .fir_enable      (fir_enable),
    .iir_enable      (iir_enable),
    .fft_read_pause  (fft_read_pause),
    .fft_write_pause (fft_write_pause),
    .fir_read_pause  (fir_read_pause),
    .fir_write_pause (fir_write_pause),
    .iir_read_pause  (iir_read_pause),
    .iir_write_pause (iir_write_pause),
    .busy            (busy),
    .job_done        (job_done),
    .error           (error),
    .rd_count        (rd_count),
    .wr_count        (wr_count)
  );

  logic [2:0] en, rp, wp;
  assign en = {iir_enable, fir_enable, fft_enable};
  assign rp = {iir_read_pause, fir_read_pause, fft_read_pause};
  assign wp = {iir_write_pause, fir_write_pause, fft_write_pause};

  typedef struct {
    logic [31:0] rd;
    logic [31:0] wr;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_read_done(input logic [1:0] sel, input logic val);
    case (sel)
      UNIT_FFT: fft_read_done = val;
      UNIT_FIR: fir_read_done = val;
      default:  iir_read_done = val;
    endcase
  endtask

  task automatic set_write_done(input logic [1:0] sel, input logic val);
    case (sel)
      UNIT_FFT: fft_write_done = val;
      UNIT_FIR: fir_write_done = val;
      default:  iir_write_done = val;
    endcase
  endtask

  // Every job_done must match a queued expectation, exactly once.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && job_done === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL job_done_unexpected: got job_done=1, required no pulse");
      end else begin
        mon_e = sb_q.pop_front();
        if (rd_count !== mon_e.rd || wr_count !== mon_e.wr) begin
          errors++;
          $display("FAIL job_counts: got rd=%0d wr=%0d, required rd=%0d wr=%0d",
                   rd_count, wr_count, mon_e.rd, mon_e.wr);
        end
      end
    end
  end

  // Runs one complete job; rd/wr toggle select a 1,0,1,0 handshake pattern.
  task automatic drive_job(input logic [1:0] sel, input int n_rd, input bit rd_toggle,
                           input int n_comp, input int n_wr, input bit wr_toggle);
    logic [2:0] oh;
    logic       r, v, released;
    int         exp_rd, exp_wr;
    exp_t       e;
    oh            = 3'b001 << sel;
    start         = 1'b1;
    unit_sel      = sel;
    dsp_in_ready  = 1'b0;
    dsp_out_valid = 1'b0;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || en !== oh || error !== 1'b0 || rp !== 3'b111) begin
      errors++;
      $display("FAIL job_start: got busy=%b en=%b err=%b rp=%b, required 1 %b 0 111",
               busy, en, error, rp, oh);
    end
    released = 1'b0;
    exp_rd   = 0;
    for (int i = 0; i < n_rd; i++) begin
      r            = rd_toggle ? (i % 2 == 0) : 1'b1;
      dsp_in_ready = r;
      tick();
      if (released) exp_rd++;
      released = r;
      checks++;
      if (rp !== (r ? ~oh : 3'b111) || wp !== 3'b111) begin
        errors++;
        $display("FAIL read_pause: got rp=%b wp=%b, required rp=%b wp=111",
                 rp, wp, r ? ~oh : 3'b111);
      end
    end
    dsp_in_ready = 1'b1;
    set_read_done(sel, 1'b1);
    tick();
    set_read_done(sel, 1'b0);
    dsp_in_ready = 1'b0;
    checks++;
    if (rp !== 3'b111 || rd_count !== exp_rd) begin
      errors++;
      $display("FAIL read_done: got rp=%b rd=%0d, required rp=111 rd=%0d", rp, rd_count, exp_rd);
    end
    for (int i = 0; i < n_comp; i++) begin
      tick();
      checks++;
      if (rp !== 3'b111 || wp !== 3'b111 || busy !== 1'b1) begin
        errors++;
        $display("FAIL compute_hold: got rp=%b wp=%b busy=%b, required 111 111 1", rp, wp, busy);
      end
    end
    dsp_out_valid = 1'b1;
    tick();
    released = 1'b1;
    exp_wr   = 0;
    checks++;
    if (wp !== ~oh) begin
      errors++;
      $display("FAIL write_enter: got wp=%b, required %b", wp, ~oh);
    end
    for (int j = 0; j < n_wr; j++) begin
      v             = wr_toggle ? (j % 2 == 1) : 1'b1;
      dsp_out_valid = v;
      tick();
      if (released) exp_wr++;
      released = v;
      checks++;
      if (wp !== (v ? ~oh : 3'b111) || rp !== 3'b111) begin
        errors++;
        $display("FAIL write_pause: got wp=%b rp=%b, required wp=%b rp=111",
                 wp, rp, v ? ~oh : 3'b111);
      end
    end
    e.rd = exp_rd;
    e.wr = exp_wr;
    sb_q.push_back(e);
    dsp_out_valid = 1'b1;
    set_write_done(sel, 1'b1);
    tick();
    set_write_done(sel, 1'b0);
    dsp_out_valid = 1'b0;
    checks++;
    if (job_done !== 1'b1 || busy !== 1'b1 || en !== oh || wp !== 3'b111) begin
      errors++;
      $display("FAIL write_done: got jd=%b busy=%b en=%b wp=%b, required 1 1 %b 111",
               job_done, busy, en, wp, oh);
    end
    tick();
    checks++;
    if (job_done !== 1'b0 || busy !== 1'b0 || en !== 3'b000) begin
      errors++;
      $display("FAIL job_end: got jd=%b busy=%b en=%b, required 0 0 000", job_done, busy, en);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (en !== 3'b000 || rp !== 3'b111 || wp !== 3'b111 || busy !== 1'b0 ||
        job_done !== 1'b0 || error !== 1'b0 || rd_count !== 0 || wr_count !== 0) begin
      errors++;
      $display("FAIL reset_values: got en=%b rp=%b wp=%b busy=%b jd=%b err=%b rd=%0d wr=%0d",
               en, rp, wp, busy, job_done, error, rd_count, wr_count);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (en !== 3'b000 || rp !== 3'b111 || wp !== 3'b111 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got en=%b rp=%b wp=%b busy=%b, required 000 111 111 0",
               en, rp, wp, busy);
    end
  endtask

  task automatic test_fft_nominal();
    drive_job(UNIT_FFT, 26, 1'b0, 2, 100, 1'b0);
    checks++;
    if (rd_count !== 32'd25 || wr_count !== 32'd100) begin
      errors++;
      $display("FAIL fft_nominal: got rd=%0d wr=%0d, required 25 100", rd_count, wr_count);
    end
  endtask

  task automatic test_illegal();
    start    = 1'b1;
    unit_sel = UNIT_ILLEGAL;
    tick();
    start = 1'b0;
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 || en !== 3'b000 || rp !== 3'b111 || wp !== 3'b111) begin
      errors++;
      $display("FAIL illegal_sel: got err=%b busy=%b en=%b rp=%b wp=%b, required 1 0 000 111 111",
               error, busy, en, rp, wp);
    end
    tick();
    checks++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL illegal_sticky: got err=%b busy=%b, required 1 0", error, busy);
    end
  endtask

  task automatic test_fir_stalls();
    drive_job(UNIT_FIR, 8, 1'b1, 1, 6, 1'b1);
    checks++;
    if (rd_count !== 32'd4 || wr_count !== 32'd3) begin
      errors++;
      $display("FAIL fir_stalls: got rd=%0d wr=%0d, required 4 3", rd_count, wr_count);
    end
  endtask

  task automatic test_watchdog();
    start    = 1'b1;
    unit_sel = UNIT_FIR;
    tick();
    start        = 1'b0;
    dsp_in_ready = 1'b1;
    tick();
    tick();
    fir_read_done = 1'b1;
    tick();
    fir_read_done = 1'b0;
    dsp_in_ready  = 1'b0;
    repeat (TO - 1) tick();
    checks++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL watchdog_early: got err=%b busy=%b, required 0 1", error, busy);
    end
    tick();
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 || en !== 3'b000 || rp !== 3'b111 || wp !== 3'b111) begin
      errors++;
      $display("FAIL watchdog_abort: got err=%b busy=%b en=%b rp=%b wp=%b, required 1 0 000 111 111",
               error, busy, en, rp, wp);
    end
    repeat (3) tick();
  endtask

  task automatic test_done_priority();
    exp_t e;
    start    = 1'b1;
    unit_sel = UNIT_IIR;
    tick();
    start        = 1'b0;
    dsp_in_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (rp !== 3'b011 || rd_count !== 32'd1) begin
      errors++;
      $display("FAIL prio_pre: got rp=%b rd=%0d, required 011 1", rp, rd_count);
    end
    iir_read_done  = 1'b1;
    iir_write_done = 1'b1;
    tick();
    iir_read_done  = 1'b0;
    iir_write_done = 1'b0;
    dsp_in_ready   = 1'b0;
    checks++;
    if (rp !== 3'b111 || wp !== 3'b111 || rd_count !== 32'd1 || job_done !== 1'b0 ||
        busy !== 1'b1) begin
      errors++;
      $display("FAIL done_priority: got rp=%b wp=%b rd=%0d jd=%b busy=%b, required 111 111 1 0 1",
               rp, wp, rd_count, job_done, busy);
    end
    start    = 1'b1;
    unit_sel = UNIT_FFT;
    tick();
    start = 1'b0;
    checks++;
    if (en !== 3'b100) begin
      errors++;
      $display("FAIL start_ignored: got en=%b, required 100", en);
    end
    dsp_out_valid = 1'b1;
    tick();
    checks++;
    if (wp !== 3'b011) begin
      errors++;
      $display("FAIL prio_compute_exit: got wp=%b, required 011", wp);
    end
    tick();
    tick();
    e.rd = 32'd1;
    e.wr = 32'd2;
    sb_q.push_back(e);
    iir_write_done = 1'b1;
    tick();
    iir_write_done = 1'b0;
    dsp_out_valid  = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_write();
    start    = 1'b1;
    unit_sel = UNIT_FFT;
    tick();
    start        = 1'b0;
    dsp_in_ready = 1'b1;
    repeat (4) tick();
    fft_read_done = 1'b1;
    tick();
    fft_read_done = 1'b0;
    dsp_in_ready  = 1'b0;
    dsp_out_valid = 1'b1;
    repeat (4) tick();
    checks++;
    if (rd_count !== 32'd3 || wr_count !== 32'd3 || wp !== 3'b110) begin
      errors++;
      $display("FAIL midwrite_pre: got rd=%0d wr=%0d wp=%b, required 3 3 110",
               rd_count, wr_count, wp);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (rp !== 3'b111 || wp !== 3'b111 || en !== 3'b000 || busy !== 1'b0 ||
        rd_count !== 0 || wr_count !== 0 || job_done !== 1'b0) begin
      errors++;
      $display("FAIL midwrite_reset: got rp=%b wp=%b en=%b busy=%b rd=%0d wr=%0d jd=%b",
               rp, wp, en, busy, rd_count, wr_count, job_done);
    end
    rst_n          = 1'b1;
    fft_write_done = 1'b1;
    tick();
    fft_write_done = 1'b0;
    dsp_out_valid  = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || en !== 3'b000) begin
      errors++;
      $display("FAIL midwrite_dropped: got busy=%b en=%b, required 0 000", busy, en);
    end
  endtask

  task automatic test_back_to_back();
    drive_job(UNIT_IIR, 5, 1'b0, 0, 4, 1'b0);
    drive_job(UNIT_FFT, 3, 1'b1, 3, 5, 1'b1);
    tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish within 200000");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    start          = 1'b0;
    unit_sel       = 2'd0;
    dsp_in_ready   = 1'b0;
    dsp_out_valid  = 1'b0;
    fft_read_done  = 1'b0;
    fft_write_done = 1'b0;
    fir_read_done  = 1'b0;
    fir_write_done = 1'b0;
    iir_read_done  = 1'b0;
    iir_write_done = 1'b0;
    test_reset();
    test_fft_nominal();
    test_illegal();
    test_fir_stalls();
    test_watchdog();
    test_done_priority();
    test_reset_mid_write();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
